// File: rtl/ps2_key_assembler.sv
// Packs received PS/2 bytes into the 65-bit ps2_key event word.
// Prefix bytes (E0/F0/E1) and the multi-byte PrtScr/Pause sequences are published as one event.
module ps2_key_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [64:0] ps2_key,
  output logic        key_stb,
  output logic        busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PAUSE   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   acc_q, acc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [64:0]   ps2_key_q;
  logic          key_stb_q;
  logic          busy_q;
  logic          pub_s;
  logic [63:0]   pub_val_s;
  logic [63:0]   acc_shift_s;
  logic [3:0]    cnt_inc_s;

  function automatic logic is_response(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hFE) || (b == 8'hAA) ||
           (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hF0);
  endfunction

  assign acc_shift_s = {acc_q[55:0], byte_in};
  assign cnt_inc_s   = cnt_q + 4'd1;

  // Next-state, accumulator and publish decision for the current cycle
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    pub_s     = 1'b0;
    pub_val_s = acc_shift_s;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (!byte_valid || is_response(byte_in)) begin
          state_d = IDLE;
        end else if (byte_in == 8'hE1) begin
          acc_d   = {56'd0, byte_in};
          cnt_d   = 4'd1;
          state_d = PAUSE;
        end else if (is_prefix(byte_in)) begin
          acc_d   = {56'd0, byte_in};
          cnt_d   = 4'd1;
          state_d = COLLECT;
        end else begin
          pub_s     = 1'b1;
          pub_val_s = {56'd0, byte_in};
          acc_d     = 64'd0;
          cnt_d     = 4'd0;
        end
      end
      COLLECT: begin
        if (byte_valid) begin
          tmo_d = '0;
          if (cnt_q == 4'd8) begin
            // a ninth byte means the sequence is garbage: drop it all
            acc_d   = 64'd0;
            cnt_d   = 4'd0;
            state_d = IDLE;
          end else if (is_prefix(byte_in) || (acc_shift_s[15:0] == 16'hE012) ||
                       (acc_shift_s[23:0] == 24'hE0F07C)) begin
            acc_d = acc_shift_s;
            cnt_d = cnt_inc_s;
          end else begin
            pub_s   = 1'b1;
            acc_d   = 64'd0;
            cnt_d   = 4'd0;
            state_d = IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          acc_d   = 64'd0;
          cnt_d   = 4'd0;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      PAUSE: begin
        if (byte_valid) begin
          tmo_d = '0;
          if (cnt_inc_s == 4'd8) begin
            pub_s   = 1'b1;
            acc_d   = 64'd0;
            cnt_d   = 4'd0;
            state_d = IDLE;
          end else begin
            acc_d = acc_shift_s;
            cnt_d = cnt_inc_s;
          end
        end else if (tmo_q == TMO_LAST) begin
          acc_d   = 64'd0;
          cnt_d   = 4'd0;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = 64'd0;
        cnt_d   = 4'd0;
        tmo_d   = '0;
      end
    endcase
  end

  // State registers and registered outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= 64'd0;
      cnt_q     <= 4'd0;
      tmo_q     <= '0;
      ps2_key_q <= 65'd0;
      key_stb_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      key_stb_q <= pub_s;
      busy_q    <= (state_d != IDLE);
      if (pub_s) begin
        ps2_key_q <= {~ps2_key_q[64], pub_val_s};
      end else begin
        ps2_key_q <= ps2_key_q;
      end
    end
  end

  assign ps2_key = ps2_key_q;
  assign key_stb = key_stb_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ps2_key_assembler.sv
// Directed and random bench for ps2_key_assembler against a byte-queue reference model.
module tb_ps2_key_assembler;

  localparam int T = 16;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [64:0] ps2_key;
  logic        key_stb;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  seq[$];
  int          idle_cnt;
  logic [64:0] m_key;
  logic        m_stb;
  int          pubs;
  int          stb_seen;
  logic [7:0]  bq[$];

  ps2_key_assembler #(.TIMEOUT_CYCLES(T)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .ps2_key   (ps2_key),
    .key_stb   (key_stb),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_seq();
    logic [63:0] v = 64'd0;
    foreach (seq[i]) v = {v[55:0], seq[i]};
    return v;
  endfunction

  task automatic model_publish(input logic [63:0] v);
    m_key = {~m_key[64], v};
    m_stb = 1'b1;
    pubs++;
    seq.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [63:0] tail;
    idle_cnt = 0;
    if (seq.size() == 0) begin
      if (b inside {8'hE0, 8'hF0, 8'hE1}) seq.push_back(b);
      else if (!(b inside {8'hFA, 8'hFE, 8'hAA, 8'hEE, 8'h00, 8'hFF})) model_publish({56'd0, b});
    end else if (seq[0] == 8'hE1) begin
      seq.push_back(b);
      if (seq.size() == 8) model_publish(pack_seq());
    end else if (seq.size() == 8) begin
      seq.delete();
    end else begin
      seq.push_back(b);
      tail = pack_seq();
      if (!(b inside {8'hE0, 8'hF0}) && tail[15:0] != 16'hE012 && tail[23:0] != 24'hE0F07C)
        model_publish(tail);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b);
    byte_valid = v;
    byte_in    = b;
    @(posedge clk_sys);
    #1;
    m_stb = 1'b0;
    if (v) begin
      model_byte(b);
    end else if (seq.size() != 0) begin
      idle_cnt++;
      if (idle_cnt >= T) begin
        seq.delete();
        idle_cnt = 0;
      end
    end
    if (key_stb) stb_seen++;
    check_eq("key", ps2_key, m_key);
    check_eq("stb", {64'd0, key_stb}, {64'd0, m_stb});
    check_eq("busy", {64'd0, busy}, {64'd0, seq.size() != 0});
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    byte_valid = 1'b0;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    seq.delete();
    idle_cnt = 0;
    m_key    = 65'd0;
    m_stb    = 1'b0;
    check_eq("rst_key", ps2_key, 65'd0);
    check_eq("rst_stb", {64'd0, key_stb}, 65'd0);
    check_eq("rst_busy", {64'd0, busy}, 65'd0);
  endtask

  task automatic send(input logic [7:0] q[$]);
    foreach (q[i]) step(1'b1, q[i]);
  endtask

  initial begin
    logic [7:0] pool[12];
    int p0;
    reset = 1'b1; byte_valid = 1'b0; byte_in = 8'd0;
    m_key = 65'd0; m_stb = 1'b0; pubs = 0; idle_cnt = 0; stb_seen = 0;
    do_reset();

    step(1'b1, 8'h1C);
    check_eq("make_1c", ps2_key, {1'b1, 56'd0, 8'h1C});
    bq = '{8'hF0, 8'h1C}; send(bq);
    check_eq("brk_1c", {48'd0, ps2_key[64], ps2_key[15:0]}, {48'd0, 1'b0, 16'hF01C});
    bq = '{8'hE0, 8'hF0, 8'h6B}; send(bq);
    check_eq("ext_brk", {41'd0, ps2_key[23:0]}, {41'd0, 24'hE0F06B});

    p0 = pubs; stb_seen = 0;
    bq = '{8'hE0, 8'h12, 8'hE0, 8'h7C}; send(bq);
    check_eq("prt_make_n", 65'(stb_seen), 65'd1);
    check_eq("prt_make", {33'd0, ps2_key[31:0]}, {33'd0, 32'hE012E07C});

    stb_seen = 0;
    bq = '{8'hE0, 8'hF0, 8'h7C, 8'hE0, 8'hF0, 8'h12}; send(bq);
    check_eq("prt_brk_n", 65'(stb_seen), 65'd1);
    check_eq("prt_brk", {17'd0, ps2_key[47:0]}, {17'd0, 48'hE0F07CE0F012});

    stb_seen = 0;
    bq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (bq[i]) begin
      step(1'b1, bq[i]);
      if (i < 7) check_eq("pause_busy", {64'd0, busy}, 65'd1);
    end
    check_eq("pause_n", 65'(stb_seen), 65'd1);
    check_eq("pause", {1'b0, ps2_key[63:0]}, {1'b0, 64'hE11477E1F014F077});

    stb_seen = 0;
    step(1'b1, 8'hE0);
    for (int i = 0; i < T + 4 && busy; i++) step(1'b0, 8'h00);
    check_eq("tmo_busy", {64'd0, busy}, 65'd0);
    check_eq("tmo_nostb", 65'(stb_seen), 65'd0);
    step(1'b1, 8'hFA);
    check_eq("fa_nostb", 65'(stb_seen), 65'd0);
    step(1'b1, 8'h29);
    check_eq("after_fa", {49'd0, ps2_key[15:0]}, {49'd0, 16'h0029});

    step(1'b1, 8'h1C);
    check_eq("b2b_1", {64'd0, key_stb}, 65'd1);
    step(1'b1, 8'h32);
    check_eq("b2b_2", {64'd0, key_stb}, 65'd1);
    check_eq("b2b_val", {49'd0, ps2_key[15:0]}, {49'd0, 16'h0032});

    step(1'b1, 8'hE0);
    do_reset();
    step(1'b0, 8'h00);
    check_eq("rst_mid", ps2_key, 65'd0);

    pool = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h7C, 8'h14,
             8'h77, 8'h1C, 8'hFA, 8'h00, 8'hE0, 8'hF0};
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        for (int g = 0; g < T + 2; g++) step(1'b0, 8'h00);
      end else if ($urandom_range(0, 3) == 0) begin
        step(1'b0, 8'($urandom));
      end else if ($urandom_range(0, 4) == 0) begin
        step(1'b1, 8'($urandom));
      end else begin
        step(1'b1, pool[$urandom_range(0, 11)]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
